qam_demod_iad: RTL and testbench

Parametrised successor to the 4-QAM moving-average demodulator. Mixes the received sample with the sin/cos local oscillator and integrates each product over one symbol period (integrate-and-dump). Each branch's dumped sum goes to a multi-level slicer, giving 4-QAM (1 bit/axis) or 16-QAM (2 bits/axis) symbols with a valid strobe. Sits between the LO/NCO and the downstream symbol sink, on the same sample clock as the modulator.

---
 rtl/qam_demod_pkg.sv | 38 +++
 rtl/qam_demod_iad_integrator.sv | 53 +++++
 rtl/qam_demod_iad.sv | 149 ++++++++++++++
 tb/tb_qam_demod_iad.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/qam_demod_pkg.sv
// Shared width derivation, Gray decision codes and the per-axis slicer for
// the integrate-and-dump QAM demodulator.
package qam_demod_pkg;

  function automatic int prod_w(input int data_w, input int lo_w);
    return data_w + lo_w;
  endfunction

  function automatic int acc_w(input int data_w, input int lo_w, input int sps);
    return prod_w(data_w, lo_w) + $clog2(sps) + 1;
  endfunction

  localparam logic [1:0] GRAY_NEG_OUTER = 2'b00;
  localparam logic [1:0] GRAY_NEG_INNER = 2'b01;
  localparam logic [1:0] GRAY_POS_INNER = 2'b11;
  localparam logic [1:0] GRAY_POS_OUTER = 2'b10;

  // 1-bit axes use only bit 0 of the result; 2-bit axes use the Gray codes.
  function automatic logic [1:0] slice_axis(input logic signed [63:0] sum,
                                            input int bits,
                                            input longint thresh);
    logic [1:0] code;
    code = '0;
    if (bits == 1) begin
      code = {1'b0, (sum > 64'sd0)};
    end else if (sum <= -thresh) begin
      code = GRAY_NEG_OUTER;
    end else if (sum <= 64'sd0) begin
      code = GRAY_NEG_INNER;
    end else if (sum <= thresh) begin
      code = GRAY_POS_INNER;
    end else begin
      code = GRAY_POS_OUTER;
    end
    return code;
  endfunction

endpackage

// File: rtl/qam_demod_iad_integrator.sv
// One I/Q branch: registered mixer product followed by an integrate-and-dump
// accumulator. Symbol framing is decided by the top level via restart_i.
module qam_iq_integrator
  import qam_demod_pkg::*;
#(
  parameter int DATA_W          = 8,
  parameter int LO_W            = 8,
  parameter int SAMPLES_PER_SYM = 16,
  localparam int PROD_W         = prod_w(DATA_W, LO_W),
  localparam int ACC_W          = acc_w(DATA_W, LO_W, SAMPLES_PER_SYM)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  input  logic signed [DATA_W-1:0] sample_i,
  input  logic signed [LO_W-1:0]   lo_i,
  input  logic                     p_valid_i,
  input  logic                     restart_i,
  output logic signed [ACC_W-1:0]  sum_o
);

  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  sum;

  always_comb begin
    prod_d = prod_q;
    if (in_valid_i) begin
      prod_d = PROD_W'(sample_i) * PROD_W'(lo_i);
    end
  end

  // sum is both the next accumulator value and the dumped symbol sum.
  always_comb begin
    prod_ext = ACC_W'(prod_q);
    sum      = restart_i ? prod_ext : acc_q + prod_ext;
    acc_d    = p_valid_i ? sum : acc_q;
  end

  assign sum_o = sum;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/qam_demod_iad.sv
// Integrate-and-dump QAM demodulator (4-QAM or 16-QAM per BITS_PER_AXIS).
// Optional soft outputs soft_sin/soft_cos when QAM_DEMOD_SOFT_OUT_EN is defined.
module qam_demod_iad
  import qam_demod_pkg::*;
#(
  parameter int DATA_W          = 8,
  parameter int LO_W            = 8,
  parameter int BITS_PER_AXIS   = 1,
  parameter int SAMPLES_PER_SYM = 16,
  parameter int THRESH          = 1024,
  localparam int ACC_W          = acc_w(DATA_W, LO_W, SAMPLES_PER_SYM)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic                         sym_sync,
  input  logic signed [DATA_W-1:0]     input_signal,
  input  logic signed [LO_W-1:0]       sin_in,
  input  logic signed [LO_W-1:0]       cos_in,
  output logic [2*BITS_PER_AXIS-1:0]   data_demod,
  output logic                         data_valid
`ifdef QAM_DEMOD_SOFT_OUT_EN
  ,
  output logic signed [ACC_W-1:0]      soft_sin,
  output logic signed [ACC_W-1:0]      soft_cos
`endif
);

  localparam int CNT_W = $clog2(SAMPLES_PER_SYM);
  localparam int BPA   = BITS_PER_AXIS;

  if (BITS_PER_AXIS != 1 && BITS_PER_AXIS != 2) begin : g_bad_bpa
    $error("qam_demod_iad: BITS_PER_AXIS must be 1 or 2");
  end
  if (SAMPLES_PER_SYM < 2) begin : g_bad_sps
    $error("qam_demod_iad: SAMPLES_PER_SYM must be >= 2");
  end
  if (THRESH <= 0) begin : g_bad_thresh
    $error("qam_demod_iad: THRESH must be positive");
  end

  logic                    p_valid_q, p_valid_d;
  logic                    p_sync_q, p_sync_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2*BPA-1:0]        data_demod_q, data_demod_d;
  logic                    data_valid_q, data_valid_d;
  logic                    restart;
  logic                    dump;
  logic signed [ACC_W-1:0] sum_s, sum_c;
  logic [1:0]              dec_s, dec_c;
  logic                    unused_dec;

  qam_iq_integrator #(
    .DATA_W         (DATA_W),
    .LO_W           (LO_W),
    .SAMPLES_PER_SYM(SAMPLES_PER_SYM)
  ) u_int_sin (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .in_valid_i(in_valid),
    .sample_i  (input_signal),
    .lo_i      (sin_in),
    .p_valid_i (p_valid_q),
    .restart_i (restart),
    .sum_o     (sum_s)
  );

  qam_iq_integrator #(
    .DATA_W         (DATA_W),
    .LO_W           (LO_W),
    .SAMPLES_PER_SYM(SAMPLES_PER_SYM)
  ) u_int_cos (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .in_valid_i(in_valid),
    .sample_i  (input_signal),
    .lo_i      (cos_in),
    .p_valid_i (p_valid_q),
    .restart_i (restart),
    .sum_o     (sum_c)
  );

  // p_valid follows in_valid every cycle so a held product is never re-added.
  always_comb begin
    p_valid_d = in_valid;
    p_sync_d  = in_valid ? sym_sync : p_sync_q;
  end

  always_comb begin
    restart = (cnt_q == '0) || p_sync_q;
    dump    = p_valid_q && !p_sync_q && (cnt_q == CNT_W'(SAMPLES_PER_SYM - 1));
    cnt_d   = cnt_q;
    if (p_valid_q) begin
      if (dump) begin
        cnt_d = '0;
      end else if (restart) begin
        cnt_d = CNT_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    dec_s        = slice_axis(64'(sum_s), BPA, longint'(THRESH));
    dec_c        = slice_axis(64'(sum_c), BPA, longint'(THRESH));
    data_demod_d = dump ? {dec_s[BPA-1:0], dec_c[BPA-1:0]} : data_demod_q;
    data_valid_d = dump;
  end

  assign unused_dec = ^{dec_s, dec_c};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid_q    <= 1'b0;
      p_sync_q     <= 1'b0;
      cnt_q        <= '0;
      data_demod_q <= '0;
      data_valid_q <= 1'b0;
    end else begin
      p_valid_q    <= p_valid_d;
      p_sync_q     <= p_sync_d;
      cnt_q        <= cnt_d;
      data_demod_q <= data_demod_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign data_demod = data_demod_q;
  assign data_valid = data_valid_q;

`ifdef QAM_DEMOD_SOFT_OUT_EN
  logic signed [ACC_W-1:0] soft_s_q, soft_c_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      soft_s_q <= '0;
      soft_c_q <= '0;
    end else if (dump) begin
      soft_s_q <= sum_s;
      soft_c_q <= sum_c;
    end
  end

  assign soft_sin = soft_s_q;
  assign soft_cos = soft_c_q;
`endif

endmodule

// File: tb/tb_qam_demod_iad.sv
// Bench for qam_demod_iad: a 4-QAM/16-sample instance and a 16-QAM/4-sample
// instance share one stimulus stream and are checked against a symbol model.
module tb_qam_demod_iad;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              sym_sync = 1'b0;
  logic signed [7:0] x_in = '0;
  logic signed [7:0] s_in = '0;
  logic signed [7:0] c_in = '0;
  logic [1:0]        dm_a;
  logic              dv_a;
  logic [3:0]        dm_b;
  logic              dv_b;
`ifdef QAM_DEMOD_SOFT_OUT_EN
  logic signed [20:0] ss_a, sc_a;
  logic signed [18:0] ss_b, sc_b;
`endif

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  qam_demod_iad dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sym_sync(sym_sync),
    .input_signal(x_in), .sin_in(s_in), .cos_in(c_in),
    .data_demod(dm_a), .data_valid(dv_a)
`ifdef QAM_DEMOD_SOFT_OUT_EN
    , .soft_sin(ss_a), .soft_cos(sc_a)
`endif
  );

  qam_demod_iad #(
    .DATA_W(8), .LO_W(8), .BITS_PER_AXIS(2), .SAMPLES_PER_SYM(4), .THRESH(1024)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sym_sync(sym_sync),
    .input_signal(x_in), .sin_in(s_in), .cos_in(c_in),
    .data_demod(dm_b), .data_valid(dv_b)
`ifdef QAM_DEMOD_SOFT_OUT_EN
    , .soft_sin(ss_b), .soft_cos(sc_b)
`endif
  );

  // Model: index 0 = instance A (4-QAM, 16 samples), 1 = instance B (16-QAM, 4 samples)
  int          sps[2] = '{16, 4};
  longint      m_ss[2], m_sc[2];
  int          m_n[2];
  bit          pend_dv[2], exp_dv[2];
  logic [3:0]  pend_dm[2], exp_dm[2];
  longint      pend_ss[2], pend_sc[2], exp_ss[2], exp_sc[2];

  function automatic logic [1:0] level16(input longint v);
    int idx;
    idx = (v <= -1024) ? 0 : (v <= 0) ? 1 : (v <= 1024) ? 2 : 3;
    return 2'(idx ^ (idx >> 1));
  endfunction

  function automatic logic [3:0] model_code(input int i, input longint ss, input longint sc);
    if (i == 0) return {2'b00, (ss > 0), (sc > 0)};
    return {level16(ss), level16(sc)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    longint ns, nc;
    int     nn;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_ss[i] <= 0; m_sc[i] <= 0; m_n[i] <= 0;
        pend_dv[i] <= 1'b0; exp_dv[i] <= 1'b0;
        pend_dm[i] <= '0; exp_dm[i] <= '0;
        pend_ss[i] <= 0; pend_sc[i] <= 0; exp_ss[i] <= 0; exp_sc[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        exp_dv[i] <= pend_dv[i];
        if (pend_dv[i]) begin
          exp_dm[i] <= pend_dm[i];
          exp_ss[i] <= pend_ss[i];
          exp_sc[i] <= pend_sc[i];
        end
        pend_dv[i] <= 1'b0;
        if (in_valid) begin
          ns = sym_sync ? 0 : m_ss[i];
          nc = sym_sync ? 0 : m_sc[i];
          nn = sym_sync ? 0 : m_n[i];
          ns = ns + longint'(x_in) * longint'(s_in);
          nc = nc + longint'(x_in) * longint'(c_in);
          nn = nn + 1;
          if (nn == sps[i]) begin
            pend_dv[i] <= 1'b1;
            pend_dm[i] <= model_code(i, ns, nc);
            pend_ss[i] <= ns;
            pend_sc[i] <= nc;
            ns = 0; nc = 0; nn = 0;
          end
          m_ss[i] <= ns; m_sc[i] <= nc; m_n[i] <= nn;
        end
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && started) begin
      chk("a_valid", longint'(dv_a), longint'(exp_dv[0]));
      chk("a_demod", longint'(dm_a), longint'(exp_dm[0]));
      chk("b_valid", longint'(dv_b), longint'(exp_dv[1]));
      chk("b_demod", longint'(dm_b), longint'(exp_dm[1]));
`ifdef QAM_DEMOD_SOFT_OUT_EN
      chk("a_soft_sin", longint'(ss_a), exp_ss[0]);
      chk("a_soft_cos", longint'(sc_a), exp_sc[0]);
      chk("b_soft_sin", longint'(ss_b), exp_ss[1]);
      chk("b_soft_cos", longint'(sc_b), exp_sc[1]);
`endif
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    started = 1'b1;
  endtask

  task automatic feed(input bit sy, input int x, input int s, input int c);
    in_valid = 1'b1;
    sym_sync = sy;
    x_in = 8'(x);
    s_in = 8'(s);
    c_in = 8'(c);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sym_sync = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called right after the last sample's feed(): strobe is visible one edge later.
  task automatic wait_strobe();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // 4-QAM baseline: S_sin=+80000, S_cos=-80000
    do_reset();
    repeat (16) feed(1'b0, 100, 50, -50);
    wait_strobe();
    chk("p1_a_valid_lit", longint'(dv_a), 1);
    chk("p1_a_demod_lit", longint'(dm_a), 2);
    chk("p1_b_demod_lit", longint'(dm_b), 4'b1000);
`ifdef QAM_DEMOD_SOFT_OUT_EN
    chk("p1_a_soft_lit", longint'(ss_a), 80000);
`endif
    idle(3);

    // 16-QAM: S_sin=1200 (outer +), S_cos=-800 (inner -)
    do_reset();
    repeat (16) feed(1'b0, 10, 30, -20);
    wait_strobe();
    chk("p2_b_valid_lit", longint'(dv_b), 1);
    chk("p2_b_demod_lit", longint'(dm_b), 4'b1001);
    idle(3);

    // Gaps in in_valid within symbols
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      feed(1'b0, 10, -30, 20);
      if (k == 2 || k == 5 || k == 13) idle(2);
    end
    wait_strobe();
    chk("p3_a_demod_lit", longint'(dm_a), 2'b01);
    chk("p3_b_demod_lit", longint'(dm_b), 4'b0011);
    idle(3);

    // sym_sync on 7th sample discards the partial symbol
    do_reset();
    repeat (6) feed(1'b0, 100, -50, 50);
    feed(1'b1, 10, 5, -5);
    repeat (14) feed(1'b0, 10, 5, -5);
    idle(1);
    chk("p4_a_no_early", longint'(dv_a), 0);
    feed(1'b0, 10, 5, -5);
    wait_strobe();
    chk("p4_a_valid_lit", longint'(dv_a), 1);
    chk("p4_a_demod_lit", longint'(dm_a), 2'b10);
    chk("p4_b_demod_lit", longint'(dm_b), 4'b1101);
    idle(3);

    // Zero sum and exactly +/-THRESH
    do_reset();
    for (int k = 0; k < 16; k++) feed(1'b0, 100, (k % 2 == 0) ? 50 : -50, 1);
    wait_strobe();
    chk("p5_a_zero_lit", longint'(dm_a), 2'b01);
    chk("p5_b_zero_lit", longint'(dm_b), 4'b0111);
    repeat (4) feed(1'b0, 16, 16, -16);
    wait_strobe();
    chk("p5_b_thresh_lit", longint'(dm_b), 4'b1100);
    idle(3);

    // Asynchronous reset mid-symbol
    do_reset();
    repeat (16) feed(1'b0, 100, 50, -50);
    repeat (5) feed(1'b0, 100, -50, 50);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("p6_a_rst_demod", longint'(dm_a), 0);
    chk("p6_a_rst_valid", longint'(dv_a), 0);
    chk("p6_b_rst_demod", longint'(dm_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (16) feed(1'b0, 10, 5, 5);
    wait_strobe();
    chk("p6_a_post_lit", longint'(dm_a), 2'b11);
    chk("p6_b_post_lit", longint'(dm_b), 4'b1111);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
